// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and three-phase sequencer (IDLE -> ACCESS -> RESP) sharing the locked data
// memory between the core (C) and the loader (L); also owns the memory lock key register.
module dmem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned KEY_WIDTH  = 8,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req,
   input  logic                  c_we,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  c_err,
   input  logic                  l_req,
   input  logic                  l_we,
   input  logic [ADDR_WIDTH-1:0] l_addr,
   input  logic [DATA_WIDTH-1:0] l_wdata,
   output logic                  l_gnt,
   output logic                  l_rvalid,
   output logic [DATA_WIDTH-1:0] l_rdata,
   output logic                  l_err,
   input  logic                  key_load,
   input  logic [KEY_WIDTH-1:0]  key_in,
   output logic                  key_ack,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wd,
   input  logic [DATA_WIDTH-1:0] m_rd,
   output logic [KEY_WIDTH-1:0]  m_key
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e                state;
   logic                  win_l;   // owner of the in-flight transaction, 1 = loader
   logic                  last_l;  // last grant went to the loader
   logic                  we_lat;
   logic                  oor;

   logic                  can_grant;
   logic                  pick_l;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_oor;
   logic [DATA_WIDTH-1:0] rd_cap;

   // Key updates take priority over requests, so grants are suppressed while key_load is high.
   always_comb begin
      can_grant = (state == StIdle) && !key_load;
      pick_l    = l_req && (!c_req || !last_l);
      c_gnt     = can_grant && c_req && !pick_l;
      l_gnt     = can_grant && l_req && pick_l;
      sel_we    = pick_l ? l_we    : c_we;
      sel_addr  = pick_l ? l_addr  : c_addr;
      sel_wdata = pick_l ? l_wdata : c_wdata;
      sel_oor   = sel_addr >= ADDR_WIDTH'(MEM_DEPTH);
      rd_cap    = oor ? '0 : m_rd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= StIdle;
         win_l    <= 1'b0;
         last_l   <= 1'b1;
         we_lat   <= 1'b0;
         oor      <= 1'b0;
         c_rvalid <= 1'b0;
         c_rdata  <= '0;
         c_err    <= 1'b0;
         l_rvalid <= 1'b0;
         l_rdata  <= '0;
         l_err    <= 1'b0;
         key_ack  <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wd     <= '0;
         m_key    <= '0;
      end else begin
         key_ack  <= 1'b0;
         c_rvalid <= 1'b0;
         l_rvalid <= 1'b0;
         m_we     <= 1'b0;
         unique case (state)
            StIdle: begin
               if (key_load) begin
                  m_key   <= key_in;
                  key_ack <= 1'b1;
               end else if (c_req || l_req) begin
                  win_l  <= pick_l;
                  last_l <= pick_l;
                  we_lat <= sel_we;
                  oor    <= sel_oor;
                  m_addr <= sel_addr;
                  m_wd   <= sel_wdata;
                  m_we   <= sel_we && !sel_oor;
                  state  <= StAccess;
               end
            end
            StAccess: begin
               // Response flags are registered here so they appear exactly during RESP.
               if (win_l) begin
                  if (!we_lat) l_rdata <= rd_cap;
                  l_rvalid <= 1'b1;
                  l_err    <= oor;
               end else begin
                  if (!we_lat) c_rdata <= rd_cap;
                  c_rvalid <= 1'b1;
                  c_err    <= oor;
               end
               state <= StResp;
            end
            StResp: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) !(c_gnt && l_gnt));
   a_rvalid_excl: assert property (@(posedge clk) disable iff (!rst) !(c_rvalid && l_rvalid));
   a_we_access: assert property (@(posedge clk) disable iff (!rst) m_we |-> state == StAccess);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, reference memory model and a
// response scoreboard fed at grant time and drained by a response monitor.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_we, l_req, l_we;
   logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
   logic        c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err;
   logic [31:0] c_rdata, l_rdata;
   logic        key_load, key_ack;
   logic [7:0]  key_in, m_key;
   logic        m_we;
   logic [31:0] m_addr, m_wd, m_rd;

   typedef struct {
      bit          port;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] last_rd [0:1];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] mem     [0:1023];
   bit          written [0:1023];

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .KEY_WIDTH (8),
      .MEM_DEPTH (1024)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .c_req   (c_req),
      .c_we    (c_we),
      .c_addr  (c_addr),
      .c_wdata (c_wdata),
      .c_gnt   (c_gnt),
      .c_rvalid(c_rvalid),
      .c_rdata (c_rdata),
      .c_err   (c_err),
      .l_req   (l_req),
      .l_we    (l_we),
      .l_addr  (l_addr),
      .l_wdata (l_wdata),
      .l_gnt   (l_gnt),
      .l_rvalid(l_rvalid),
      .l_rdata (l_rdata),
      .l_err   (l_err),
      .key_load(key_load),
      .key_in  (key_in),
      .key_ack (key_ack),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wd    (m_wd),
      .m_rd    (m_rd),
      .m_key   (m_key)
   );

   function automatic logic [31:0] dflt(input logic [9:0] idx);
      return (idx == 10'd28) ? 32'h0000_0020 : (32'h1000 + 32'(idx));
   endfunction

   // Memory aliases on the low address bits so a stray out-of-range write would corrupt it.
   assign m_rd = written[m_addr[9:0]] ? mem[m_addr[9:0]] : dflt(m_addr[9:0]);

   always @(posedge clk) begin
      if (m_we) begin
         mem[m_addr[9:0]]     <= m_wd;
         written[m_addr[9:0]] <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (c_rvalid === 1'b1 && l_rvalid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rvalid_both: both rvalid high, required at most one");
         end else if (c_rvalid === 1'b1 || l_rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: c_rvalid=%b l_rvalid=%b, required none", c_rvalid,
                        l_rvalid);
            end else begin
               exp_t e;
               bit   p;
               e = exp_q.pop_front();
               p = l_rvalid;
               if (p !== e.port || (p ? l_rdata : c_rdata) !== e.data ||
                   (p ? l_err : c_err) !== e.err) begin
                  errors++;
                  $display("FAIL resp: port=%0d rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                           p, p ? l_rdata : c_rdata, p ? l_err : c_err, e.port, e.data, e.err);
               end
            end
         end
      end
   end

   task automatic drive_req(input bit port, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd);
      if (port) begin
         l_req = req; l_we = we; l_addr = addr; l_wdata = wd;
      end else begin
         c_req = req; c_we = we; c_addr = addr; c_wdata = wd;
      end
   endtask

   task automatic push_exp(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd);
      exp_t e;
      bit   inr;
      inr    = addr < 1024;
      e.port = port;
      e.err  = !inr;
      if (we) begin
         if (inr) ref_mem[addr[9:0]] = wd;
         e.data = last_rd[port];
      end else begin
         e.data = inr ? ref_mem[addr[9:0]] : 32'h0;
      end
      last_rd[port] = e.data;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the response.
   task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd);
      bit got = 0;
      drive_req(port, 1'b1, we, addr, wd);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if ((port ? l_gnt : c_gnt) === 1'b1) got = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL gnt_timeout: port %0d got no gnt, required gnt", port);
         drive_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
         return;
      end
      push_exp(port, we, addr, wd);
      @(posedge clk); #1;
      drive_req(port, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (m_we !== (we && addr < 1024)) begin
         errors++;
         $display("FAIL m_we_access: m_we=%b, required %b", m_we, we && addr < 1024);
      end
      checks++;
      if (m_addr !== addr) begin
         errors++;
         $display("FAIL m_addr_access: m_addr=%h, required %h", m_addr, addr);
      end
      @(posedge clk); #1;
      checks++;
      if ((port ? l_rvalid : c_rvalid) !== 1'b1 || m_we !== 1'b0) begin
         errors++;
         $display("FAIL resp_timing: rvalid=%b m_we=%b, required rvalid=1 m_we=0",
                  port ? l_rvalid : c_rvalid, m_we);
      end
      @(posedge clk); #1;
   endtask

   task automatic drain;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
      key_load = 0; key_in = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, key_ack, m_we} !== 8'h00 ||
          c_rdata !== 0 || l_rdata !== 0 || m_addr !== 0 || m_wd !== 0 || m_key !== 0) begin
         errors++;
         $display("FAIL reset_state: outputs not all zero (m_key=%h m_addr=%h), required zero",
                  m_key, m_addr);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_contention;
      int  last_cyc = -1;
      int  ngnt     = 0;
      bit  nxt_l    = 0;
      drive_req(0, 1'b1, 1'b0, 32'd28, 32'h0);
      drive_req(1, 1'b1, 1'b0, 32'd100, 32'h0);
      #1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (c_gnt === 1'b1 || l_gnt === 1'b1) begin
            checks++;
            if (c_gnt === 1'b1 && l_gnt === 1'b1) begin
               errors++;
               $display("FAIL gnt_both: both gnt high in cycle %0d, required one", cyc);
            end else if (l_gnt !== nxt_l || (last_cyc >= 0 && cyc - last_cyc != 3)) begin
               errors++;
               $display("FAIL contention: gnt to %0d at cycle %0d, required %0d at cycle %0d",
                        l_gnt, cyc, nxt_l, last_cyc < 0 ? 0 : last_cyc + 3);
            end
            push_exp(l_gnt, 1'b0, l_gnt ? 32'd100 : 32'd28, 32'h0);
            nxt_l    = !l_gnt;
            last_cyc = cyc;
            ngnt++;
         end
         @(posedge clk); #2;
      end
      drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (ngnt != 4) begin
         errors++;
         $display("FAIL contention_count: %0d grants, required 4", ngnt);
      end
      drain();
      @(posedge clk); #1;
   endtask

   task automatic test_single_read;
      txn(0, 1'b0, 32'd28, 32'h0);
   endtask

   task automatic test_write_read;
      txn(1, 1'b1, 32'd40, 32'h2);
      txn(1, 1'b0, 32'd40, 32'h0);
      txn(0, 1'b1, 32'd7, 32'hA5A5_0007);
      txn(1, 1'b0, 32'd7, 32'h0);
   endtask

   task automatic test_out_of_range;
      txn(0, 1'b1, 32'd1024, 32'h0000_FFFF);
      txn(0, 1'b0, 32'd0, 32'h0);
      txn(1, 1'b0, 32'd1030, 32'h0);
      txn(1, 1'b0, 32'd1023, 32'h0);
   endtask

   task automatic test_key_update;
      key_load = 1'b1;
      key_in   = 8'h0F;
      drive_req(0, 1'b1, 1'b0, 32'd28, 32'h0);
      #1;
      checks++;
      if (c_gnt !== 1'b0 || l_gnt !== 1'b0) begin
         errors++;
         $display("FAIL key_no_gnt: c_gnt=%b l_gnt=%b, required 0", c_gnt, l_gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (m_key !== 8'h0F || key_ack !== 1'b1) begin
         errors++;
         $display("FAIL key_update: m_key=%h key_ack=%b, required 0f 1", m_key, key_ack);
      end
      key_load = 1'b0;
      #1;
      checks++;
      if (c_gnt !== 1'b1) begin
         errors++;
         $display("FAIL key_then_gnt: c_gnt=%b, required 1", c_gnt);
      end else begin
         push_exp(0, 1'b0, 32'd28, 32'h0);
      end
      @(posedge clk); #1;
      drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (key_ack !== 1'b0 || m_key !== 8'h0F) begin
         errors++;
         $display("FAIL key_ack_pulse: key_ack=%b m_key=%h, required 0 0f", key_ack, m_key);
      end
      drain();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op;
      drive_req(1, 1'b1, 1'b1, 32'd50, 32'hDEAD);
      #1;
      checks++;
      if (l_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midop_gnt: l_gnt=%b, required 1", l_gnt);
      end
      @(posedge clk); #1;
      drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (m_we !== 1'b1) begin
         errors++;
         $display("FAIL midop_access: m_we=%b, required 1", m_we);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (m_we !== 1'b0 || m_key !== 8'h00 || l_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset: m_we=%b m_key=%h l_rvalid=%b, required 0 00 0", m_we, m_key,
                  l_rvalid);
      end
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (l_rvalid !== 1'b0 || written[50]) begin
         errors++;
         $display("FAIL midop_dropped: l_rvalid=%b mem_written=%b, required 0 0", l_rvalid,
                  written[50]);
      end
      txn(1, 1'b0, 32'd50, 32'h0);
      txn(0, 1'b0, 32'd28, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = dflt(10'(i));
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      test_reset();
      test_contention();
      test_single_read();
      test_write_read();
      test_out_of_range();
      test_key_update();
      test_reset_mid_op();
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the locked data memory. It shares the single data memory port between the core load/store unit (port C) and the program/debug loader (port L) using round-robin arbitration. It sequences every access as a fixed three-phase transaction and owns the memory's 8-bit lock key register, which changes only between transactions. It sits between the core/loader and the data memory instance.

## Interface
- ADDR_WIDTH, 32, byte/word address width presented to memory
- DATA_WIDTH, 32, read/write data width
- KEY_WIDTH, 8, lock key width
- MEM_DEPTH, 1024, number of valid memory words; addresses >= MEM_DEPTH are out of range

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- c_req, l_req  in  1  access request; held with its fields stable until the matching gnt
- c_we, l_we  in  1  1 = write, 0 = read
- c_addr, l_addr  in  ADDR_WIDTH  access address
- c_wdata, l_wdata  in  DATA_WIDTH  write data
- c_gnt, l_gnt  out  1  request accepted this cycle (combinational, IDLE only)
- c_rvalid, l_rvalid  out  1  one-cycle response pulse
- c_rdata, l_rdata  out  DATA_WIDTH  read data, valid with rvalid, held until next response to that port
- c_err, l_err  out  1  out-of-range flag, valid with rvalid
- key_load  in  1  request to update the lock key
- key_in  in  KEY_WIDTH  new key value
- key_ack  out  1  one-cycle pulse when key updated
- m_we  out  1  memory write enable
- m_addr  out  ADDR_WIDTH  memory address
- m_wd  out  DATA_WIDTH  memory write data
- m_rd  in  DATA_WIDTH  memory read data (combinational from m_addr)
- m_key  out  KEY_WIDTH  registered lock key to memory

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE with key_load=1:
  - m_key <= key_in; key_ack pulses next cycle.
  - No grant this cycle; key update has priority over requests.
- IDLE with key_load=0 and any req:
  - Pick the winner and assert its gnt.
  - Latch we/addr/wdata and the winner id.
  - Compute range flag = (addr >= MEM_DEPTH).
  - Go to ACCESS.
- Arbitration: a single requester wins outright. With both requesting, the port not granted last wins. last_grant resets to L, so C wins the first tie.
- ACCESS:
  - m_addr/m_wd hold latched values.
  - m_we = latched we AND in-range, for this cycle only.
  - For a read, m_rd is captured into the winner's rdata at the end of ACCESS. Out-of-range reads capture 0.
  - Writes leave rdata unchanged.
  - Go to RESP.
- RESP:
  - The winner's rvalid pulses; its err = range flag.
  - Return to IDLE, where the next request can be granted on the following cycle.
- m_addr/m_wd keep their last values outside ACCESS. m_we is 0 outside ACCESS.
- Reset (async, any state):
  - All outputs to 0, including m_key = 0 and m_we = 0 immediately.
  - State to IDLE; any in-flight transaction is dropped with no response.
  - last_grant = L.

## Timing
- Request accepted in cycle T (gnt high, combinational from req in IDLE).
- ACCESS in T+1; a write commits at the clk edge ending T+1.
- rvalid, rdata and err are valid in T+2.
- Back-to-back throughput: one transaction per 3 cycles. Next gnt at T+3 at the earliest.
- Key load accepted in IDLE at cycle K: m_key changes at the edge ending K, key_ack is high in K+1, state stays IDLE. A pending req is granted in K+1 if key_load has dropped.
- key_load outside IDLE is ignored until IDLE; the source holds it high.
- gnt is never high outside IDLE. At most one gnt per cycle.
- rvalid pulses are exactly one cycle. c_rvalid and l_rvalid are never high together.

## Test plan
- Single read: preload mem[28]=0x00000020, c_req read addr 28 at T -> c_gnt at T, m_we=0 in T+1, c_rvalid with c_rdata=0x00000020 and c_err=0 at T+2.
- Write then read: l_req write addr 40 data 0x2 -> m_we=1 only in T+1, l_rvalid at T+2. A following l read of 40 returns 0x00000002.
- Contention: c_req and l_req held high continuously -> grants alternate C, L, C, L at 3-cycle spacing, C first after reset, and each port gets its own response.
- Out of range: c_req write addr 1024 data 0xFFFF -> m_we stays 0, c_rvalid with c_err=1 at T+2, and memory is unchanged (read back of addr 0 is unaffected).
- Key update: key_load=1, key_in=0x0F together with c_req in IDLE -> no gnt that cycle, m_key=0x0F next cycle with key_ack=1, c_gnt one cycle later.
- Reset mid-op: drop rst during ACCESS of a write -> m_we=0 immediately, m_key=0, no rvalid, memory unchanged. After release, the next request completes normally.
